// File: rtl/ocram_pkg.sv
// Shared types and constants for the OCRAM write master.
// Holds the FSM state encoding, Avalon bus widths and the address alignment helper.
package ocram_pkg;

    localparam int AVM_ADDR_W = 32;
    localparam int AVM_DATA_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    function automatic logic is_word_aligned(input logic [AVM_ADDR_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ocram_sample_fifo.sv
// Synchronous sample FIFO with register storage and extended pointers.
// Exposes the head and the entry behind it so the writer can chain writes without a bubble.
module ocram_sample_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] next_head,
    output logic             full,
    output logic             empty,
    output logic             more
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_ptr_inc;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign rd_ptr_inc = rd_ptr + (AW + 1)'(1);
    assign count      = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // More than one entry: the second one is valid to read.
    assign more       = (count > (AW + 1)'(1));
    assign head       = mem[rd_ptr[AW-1:0]];
    assign next_head  = mem[rd_ptr_inc[AW-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
        end
    end

endmodule

// File: rtl/ocram_writer_master.sv
// Avalon-MM write master: buffers conduit bytes and writes each one as a single byte lane
// into a ring region of the HPS on-chip RAM.
module ocram_writer_master
    import ocram_pkg::*;
#(
    parameter logic [AVM_ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned           RING_BYTES = 64,
    parameter int unsigned           FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            conduit_data,
    input  logic                  conduit_valid,
    output logic                  conduit_ready,
    output logic [AVM_ADDR_W-1:0] avm_address,
    output logic                  avm_write,
    output logic [AVM_DATA_W-1:0] avm_writedata,
    output logic [3:0]            avm_byteenable,
    input  logic                  avm_waitrequest,
    output logic                  busy,
    output logic [15:0]           wr_count
);
    localparam int unsigned IDX_W = $clog2(RING_BYTES);
    // Low address bits are dropped if a misaligned base slips through.
    localparam logic [AVM_ADDR_W-1:0] BASE =
        is_word_aligned(BASE_ADDR) ? BASE_ADDR : (BASE_ADDR & ~AVM_ADDR_W'(3));

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d, idx_inc;
    logic [AVM_ADDR_W-1:0]   addr_q, addr_d;
    logic [AVM_DATA_W-1:0]   data_q, data_d;
    logic [3:0]              be_q, be_d;
    logic [15:0]             count_q, count_d;
    logic                    push, pop, full, empty, more;
    logic [7:0]              head, next_head, load_byte;
    logic                    load;
    logic [IDX_W-1:0]        load_idx;

    function automatic logic [AVM_ADDR_W-1:0] ring_addr(input logic [IDX_W-1:0] i);
        return BASE + (AVM_ADDR_W'(i) & ~AVM_ADDR_W'(3));
    endfunction

    ocram_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (conduit_data),
        .pop       (pop),
        .head      (head),
        .next_head (next_head),
        .full      (full),
        .empty     (empty),
        .more      (more)
    );

    assign conduit_ready = !full;
    assign push          = conduit_valid && conduit_ready;
    assign idx_inc       = idx_q + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        count_d   = count_q;
        pop       = 1'b0;
        load      = 1'b0;
        load_idx  = idx_q;
        load_byte = head;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    load    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!avm_waitrequest) begin
                    pop      = 1'b1;
                    idx_d    = idx_inc;
                    load_idx = idx_inc;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    // A byte arriving into a single-entry FIFO is forwarded straight from the conduit.
                    if (more || push) begin
                        load      = 1'b1;
                        load_byte = more ? next_head : conduit_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign addr_d = load ? ring_addr(load_idx) : addr_q;
    assign data_d = load ? {4{load_byte}} : data_q;
    assign be_d   = load ? (4'b0001 << load_idx[1:0]) : be_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= BASE;
            data_q  <= '0;
            be_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            count_q <= count_d;
        end
    end

    assign avm_write      = (state_q == WRITE);
    assign avm_address    = addr_q;
    assign avm_writedata  = data_q;
    assign avm_byteenable = be_q;
    assign wr_count       = count_q;
    assign busy           = (state_q == WRITE) || !empty;

endmodule

// File: tb/tb_ocram_writer_master.sv
// Bench for ocram_writer_master: directed scenarios plus random traffic, checked against a
// queue-based model of accepted samples, ring index arithmetic and handshake timing.
module tb_ocram_writer_master;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          RING  = 64;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  conduit_data;
    logic        conduit_valid;
    logic        conduit_ready;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic        busy;
    logic [15:0] wr_count;

    int          tests = 0;
    int          fails = 0;

    // Reference model state
    logic [7:0]  q[$];
    int unsigned m_idx = 0;
    int unsigned m_count = 0;
    int unsigned writes_seen = 0;
    int          mon_occ;
    int          prev_occ = 0;
    logic        prev_write = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_addr, prev_data;
    logic [3:0]  prev_be;
    logic [31:0] last_addr = '0;
    logic [3:0]  last_be = '0;

    ocram_writer_master #(
        .BASE_ADDR  (BASE),
        .RING_BYTES (RING),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .conduit_data    (conduit_data),
        .conduit_valid   (conduit_valid),
        .conduit_ready   (conduit_ready),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .wr_count        (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a sample waits in the queue until its write is accepted; a write is presented
    // when a sample waits and the master was already writing or the sample waited a cycle.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            m_idx      = 0;
            m_count    = 0;
            prev_write = 1'b0;
            stall_prev = 1'b0;
            prev_occ   = 0;
        end else begin
            mon_occ = q.size();
            check("ready", conduit_ready, mon_occ < DEPTH);
            check("busy", busy, mon_occ != 0);
            check("wr_count", wr_count, m_count);
            check("write_timing", avm_write, (mon_occ != 0) && (prev_write || prev_occ != 0));
            if (stall_prev) begin
                check("hold_addr", avm_address, prev_addr);
                check("hold_data", avm_writedata, prev_data);
                check("hold_be", avm_byteenable, prev_be);
            end
            if (avm_write && mon_occ != 0) begin
                check("be_onehot", $onehot(avm_byteenable), 1);
                check("addr", avm_address, BASE + (m_idx & ~32'd3));
                check("data", avm_writedata, {4{q[0]}});
                check("be", avm_byteenable, 4'b0001 << (m_idx % 4));
                if (!avm_waitrequest) begin
                    last_addr = avm_address;
                    last_be   = avm_byteenable;
                    void'(q.pop_front());
                    m_idx = (m_idx + 1) % RING;
                    if (m_count < 32'hFFFF) m_count++;
                    writes_seen++;
                end
            end
            prev_write = avm_write;
            stall_prev = avm_write && avm_waitrequest;
            prev_addr  = avm_address;
            prev_data  = avm_writedata;
            prev_be    = avm_byteenable;
            prev_occ   = mon_occ;
            if (conduit_valid && conduit_ready) q.push_back(conduit_data);
        end
    end

    // All stimulus changes happen 1 time unit after a rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic w);
        conduit_valid   = v;
        conduit_data    = d;
        avm_waitrequest = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        conduit_valid   = 1'b0;
        avm_waitrequest = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        conduit_valid   = 1'b0;
        avm_waitrequest = 1'b0;
        while ((q.size() != 0 || busy) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", (q.size() == 0) && !busy, 1);
    endtask

    initial begin
        int unsigned base_writes;
        reset           = 1'b1;
        conduit_valid   = 1'b0;
        conduit_data    = '0;
        avm_waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_write", avm_write, 0);
        check("rst_addr", avm_address, BASE);
        check("rst_data", avm_writedata, 0);
        check("rst_be", avm_byteenable, 0);
        check("rst_count", wr_count, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // Single write with one-cycle load latency
        step(1'b1, 8'hA5, 1'b0);
        check("t1_lat0", avm_write, 0);
        step(1'b0, 8'h00, 1'b0);
        check("t1_lat1", avm_write, 1);
        check("t1_data", avm_writedata, 32'hA5A5_A5A5);
        drain(20);
        check("t1_count", wr_count, 1);
        check("t1_busy", busy, 0);
        check("t1_addr", last_addr, BASE);
        check("t1_be", last_be, 4'b0001);

        // Back-to-back burst from a fresh ring position
        do_reset();
        base_writes = writes_seen;
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h44, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        drain(30);
        check("t2_writes", writes_seen - base_writes, 5);
        check("t2_addr", last_addr, BASE + 32'd4);
        check("t2_be", last_be, 4'b0001);

        // Stall while the FIFO fills; the fifth sample must be refused
        base_writes = writes_seen;
        for (int i = 0; i < 8; i++) step(1'b1, 8'hC0 + 8'(i), 1'b1);
        check("t3_ready", conduit_ready, 0);
        check("t3_stalled", avm_write, 1);
        drain(30);
        check("t3_writes", writes_seen - base_writes, DEPTH);

        // Ring wrap after RING_BYTES writes
        do_reset();
        for (int i = 0; i <= RING; i++) step(1'b1, 8'(i * 7 + 3), 1'b0);
        drain(200);
        check("t4_count", wr_count, RING + 1);
        check("t4_addr", last_addr, BASE);
        check("t4_be", last_be, 4'b0001);

        // Asynchronous reset in the middle of a stalled write
        step(1'b1, 8'h5A, 1'b1);
        step(1'b1, 8'h6B, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("t5_writing", avm_write, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_write_drop", avm_write, 0);
        check("t5_count", wr_count, 0);
        check("t5_busy", busy, 0);
        check("t5_ready", conduit_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 8'h77, 1'b0);
        drain(20);
        check("t5_addr", last_addr, BASE);
        check("t5_be", last_be, 4'b0001);
        check("t5_count1", wr_count, 1);

        // Saturation of the completed-write counter
        force dut.count_q = 16'hFFFE;
        m_count = 32'hFFFE;
        #1;
        release dut.count_q;
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        drain(20);
        check("t6_sat", wr_count, 16'hFFFF);

        // Random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) == 0);
        end
        drain(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
